// File: rtl/alu_ctrl_path.sv
// alu_ctrl_path: MIPS ID main decoder, EX ALU control and 32-bit ALU with HI/LO/FPC state.
// Define ALU_MULT_EN to build mult/multu, the HI/LO registers and mfhi/mflo.
module alu_ctrl_path (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_op,
  input  logic [5:0]  id_fun,
  input  logic [4:0]  id_fmt,
  output logic        c_jr,
  output logic        c_byte,
  output logic        c_jump,
  output logic        c_mem_write,
  output logic        c_reg_write,
  output logic        c_float,
  output logic        c_shift,
  output logic        c_dw,
  output logic [1:0]  c_reg_dst,
  output logic [1:0]  c_wb_src,
  output logic [2:0]  c_ex_op,
  input  logic [2:0]  ex_op,
  input  logic [5:0]  ex_fun,
  input  logic [4:0]  ex_fmt,
  input  logic        ex_ft0,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_rt,
  input  logic [15:0] ex_imm,
  input  logic        ex_kill,
  input  logic        fp_cond,
  output logic [31:0] ex_result,
  output logic [31:0] ex_out2,
  output logic        ex_overflow,
  output logic        ex_zero,
  output logic        br_taken,
  output logic        fpc
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4, NOR = 4'd5,
                         SLT = 4'd6, SLTU = 4'd7, SLL = 4'd8, SRL = 4'd9, SRA = 4'd10,
                         MULT = 4'd11, MULTU = 4'd12;
  always_comb begin
    c_jr = 1'b0;
    c_byte = 1'b0;
    c_jump = 1'b0;
    c_mem_write = 1'b0;
    c_reg_write = 1'b0;
    c_float = 1'b0;
    c_shift = 1'b0;
    c_dw = 1'b0;
    c_reg_dst = 2'd0;
    c_wb_src = 2'd0;
    c_ex_op = 3'b000;
    case (id_op)
      6'h00:
        case (id_fun)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: c_reg_write = 1'b1;
`ifdef ALU_MULT_EN
          6'h10, 6'h12: c_reg_write = 1'b1;
`endif
          6'h00, 6'h02, 6'h03: begin c_reg_write = 1'b1; c_shift = 1'b1; end
          6'h08: begin c_jump = 1'b1; c_jr = 1'b1; end
          default: ;
        endcase
      6'h02: c_jump = 1'b1;
      6'h03: begin c_jump = 1'b1; c_reg_write = 1'b1; c_reg_dst = 2'd3; c_wb_src = 2'd3; end
      6'h04: c_ex_op = 3'b010;
      6'h05: c_ex_op = 3'b011;
      6'h08, 6'h09: begin c_reg_write = 1'b1; c_reg_dst = 2'd1; c_ex_op = 3'b001; end
      6'h0a: begin c_reg_write = 1'b1; c_reg_dst = 2'd1; c_ex_op = 3'b100; end
      6'h0c: begin c_reg_write = 1'b1; c_reg_dst = 2'd1; c_ex_op = 3'b101; end
      6'h0d: begin c_reg_write = 1'b1; c_reg_dst = 2'd1; c_ex_op = 3'b110; end
      6'h0f: begin c_reg_write = 1'b1; c_reg_dst = 2'd1; c_wb_src = 2'd2; c_ex_op = 3'b001; end
      6'h20, 6'h23: begin
        c_reg_write = 1'b1;
        c_reg_dst = 2'd1;
        c_wb_src = 2'd1;
        c_ex_op = 3'b001;
        c_byte = id_op == 6'h20;
      end
      6'h28, 6'h2b: begin c_mem_write = 1'b1; c_ex_op = 3'b001; c_byte = id_op == 6'h28; end
      6'h31, 6'h35: begin
        c_float = 1'b1;
        c_reg_write = 1'b1;
        c_reg_dst = 2'd1;
        c_wb_src = 2'd1;
        c_ex_op = 3'b001;
        c_dw = id_op == 6'h35;
      end
      6'h39, 6'h3d: begin c_float = 1'b1; c_mem_write = 1'b1; c_ex_op = 3'b001; c_dw = id_op == 6'h3d; end
      6'h11: begin
        c_float = 1'b1;
        c_ex_op = 3'b111;
        if ((id_fmt == 5'h10 || id_fmt == 5'h11) && id_fun[5:4] != 2'b11) begin
          c_reg_write = 1'b1;
          c_reg_dst = 2'd2;
          c_dw = id_fmt[0];
        end
      end
      default: ;
    endcase
  end
  logic [3:0]  con;
  logic [31:0] b, out1, sum, dif;
  logic        br, eq_ne, br_fpc, fpc_w, fpc_d, fpc_q;
`ifdef ALU_MULT_EN
  logic        hilo_w, sel_hi, sel_lo, sx;
  logic [31:0] hi_d, hi_q, lo_d, lo_q;
  logic [63:0] prod;
`endif
  always_comb begin
    con = ADD;
    b = ex_rt;
    br = 1'b0;
    eq_ne = 1'b0;
    br_fpc = 1'b0;
    fpc_w = 1'b0;
`ifdef ALU_MULT_EN
    hilo_w = 1'b0;
    sel_hi = 1'b0;
    sel_lo = 1'b0;
`endif
    case (ex_op)
      3'b000:
        case (ex_fun)
          6'h22, 6'h23: con = SUB;
          6'h24: con = AND;
          6'h25: con = OR;
          6'h26: con = XOR;
          6'h27: con = NOR;
          6'h2a: con = SLT;
          6'h2b: con = SLTU;
          6'h00: con = SLL;
          6'h02: con = SRL;
          6'h03: con = SRA;
`ifdef ALU_MULT_EN
          6'h18: begin con = MULT; hilo_w = 1'b1; end
          6'h19: begin con = MULTU; hilo_w = 1'b1; end
          6'h10: sel_hi = 1'b1;
          6'h12: sel_lo = 1'b1;
`endif
          default: con = ADD;
        endcase
      3'b001: b = {{16{ex_imm[15]}}, ex_imm};
      3'b100: begin con = SLT; b = {{16{ex_imm[15]}}, ex_imm}; end
      3'b101: begin con = AND; b = {16'h0, ex_imm}; end
      3'b110: begin con = OR; b = {16'h0, ex_imm}; end
      3'b010, 3'b011: begin con = SUB; br = 1'b1; eq_ne = ex_op[0]; end
      default:
        if (ex_fmt == 5'h08) begin
          br = 1'b1;
          br_fpc = 1'b1;
          eq_ne = ~ex_ft0;
        end else fpc_w = ex_fun[5:4] == 2'b11;
    endcase
  end
  assign sum = ex_a + b;
  assign dif = ex_a - b;
`ifdef ALU_MULT_EN
  // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
  assign sx = con == MULT;
  assign prod = {{32{sx & ex_a[31]}}, ex_a} * {{32{sx & b[31]}}, b};
`endif
  always_comb begin
    out1 = 32'h0;
    case (con)
      ADD:   out1 = sum;
      SUB:   out1 = dif;
      AND:   out1 = ex_a & b;
      OR:    out1 = ex_a | b;
      XOR:   out1 = ex_a ^ b;
      NOR:   out1 = ~(ex_a | b);
      SLT:   out1 = {31'h0, $signed(ex_a) < $signed(b)};
      SLTU:  out1 = {31'h0, ex_a < b};
      SLL:   out1 = b << ex_a[4:0];
      SRL:   out1 = b >> ex_a[4:0];
      SRA:   out1 = $signed(b) >>> ex_a[4:0];
`ifdef ALU_MULT_EN
      MULT, MULTU: out1 = prod[31:0];
`endif
      default: out1 = 32'h0;
    endcase
  end
  assign ex_zero = out1 == 32'h0;
  assign ex_overflow = (con == ADD && ex_a[31] == b[31] && sum[31] != ex_a[31]) ||
                       (con == SUB && ex_a[31] != b[31] && dif[31] != ex_a[31]);
  assign br_taken = (eq_ne ^ (br_fpc ? fpc_q : ex_zero)) & br;
  assign fpc_d = (fpc_w & ~ex_kill) ? fp_cond : fpc_q;
  assign fpc = fpc_q;
  always_ff @(posedge clk)
    if (!rst_n) fpc_q <= 1'b0;
    else fpc_q <= fpc_d;
`ifdef ALU_MULT_EN
  assign hi_d = (hilo_w & ~ex_kill) ? prod[63:32] : hi_q;
  assign lo_d = (hilo_w & ~ex_kill) ? prod[31:0] : lo_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  assign ex_out2 = hilo_w ? prod[63:32] : 32'h0;
  assign ex_result = sel_hi ? hi_q : sel_lo ? lo_q : out1;
`else
  assign ex_out2 = 32'h0;
  assign ex_result = out1;
`endif
endmodule

// File: tb/tb_alu_ctrl_path.sv
// tb_alu_ctrl_path: table-driven decode/ALU vectors plus FPC and HI/LO sequences.
module tb_alu_ctrl_path;
  logic        clk = 1'b0, rst_n;
  logic [5:0]  id_op, id_fun, ex_fun;
  logic [4:0]  id_fmt, ex_fmt;
  logic [2:0]  ex_op, c_ex_op;
  logic        ex_ft0, ex_kill, fp_cond;
  logic [31:0] ex_a, ex_rt, ex_result, ex_out2;
  logic [15:0] ex_imm;
  logic        c_jr, c_byte, c_jump, c_mem_write, c_reg_write, c_float, c_shift, c_dw;
  logic [1:0]  c_reg_dst, c_wb_src;
  logic        ex_overflow, ex_zero, br_taken, fpc;
  logic [14:0] ctrl;
  int n_cmp = 0, n_fail = 0;

  alu_ctrl_path dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_fun(id_fun), .id_fmt(id_fmt),
    .c_jr(c_jr), .c_byte(c_byte), .c_jump(c_jump), .c_mem_write(c_mem_write),
    .c_reg_write(c_reg_write), .c_float(c_float), .c_shift(c_shift), .c_dw(c_dw),
    .c_reg_dst(c_reg_dst), .c_wb_src(c_wb_src), .c_ex_op(c_ex_op),
    .ex_op(ex_op), .ex_fun(ex_fun), .ex_fmt(ex_fmt), .ex_ft0(ex_ft0), .ex_a(ex_a),
    .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_kill(ex_kill), .fp_cond(fp_cond),
    .ex_result(ex_result), .ex_out2(ex_out2), .ex_overflow(ex_overflow),
    .ex_zero(ex_zero), .br_taken(br_taken), .fpc(fpc)
  );

  always #5 clk = ~clk;
  // Field order: jr byte jump mem_write reg_write float shift dw | dst | wb | ex_op
  assign ctrl = {c_jr, c_byte, c_jump, c_mem_write, c_reg_write, c_float, c_shift, c_dw,
                 c_reg_dst, c_wb_src, c_ex_op};

  typedef struct {
    logic [5:0] op, fun;
    logic [4:0] fmt;
    logic [14:0] exp;
  } dec_t;
  typedef struct {
    logic [2:0] op;
    logic [5:0] fun;
    logic [31:0] a, rt;
    logic [15:0] imm;
    logic [31:0] res;
    logic ovf, zero, br;
  } alu_t;

  localparam int ND = 18, NA = 19;
  dec_t dec[ND];
  alu_t alu[NA];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [2:0] op, input logic [5:0] fun, input logic [4:0] fmt,
                        input logic ft0, input logic [31:0] a, input logic [31:0] rt);
    ex_op = op; ex_fun = fun; ex_fmt = fmt; ex_ft0 = ft0; ex_a = a; ex_rt = rt;
  endtask

  initial begin
    dec[0]  = '{6'h00, 6'h20, 5'h00, 15'b0000_1000_00_00_000};
    dec[1]  = '{6'h00, 6'h03, 5'h00, 15'b0000_1010_00_00_000};
    dec[2]  = '{6'h00, 6'h08, 5'h00, 15'b1010_0000_00_00_000};
    dec[3]  = '{6'h00, 6'h01, 5'h00, 15'b0000_0000_00_00_000};
    dec[4]  = '{6'h03, 6'h00, 5'h00, 15'b0010_1000_11_11_000};
    dec[5]  = '{6'h05, 6'h00, 5'h00, 15'b0000_0000_00_00_011};
    dec[6]  = '{6'h0c, 6'h00, 5'h00, 15'b0000_1000_01_00_101};
    dec[7]  = '{6'h0f, 6'h00, 5'h00, 15'b0000_1000_01_10_001};
    dec[8]  = '{6'h20, 6'h00, 5'h00, 15'b0100_1000_01_01_001};
    dec[9]  = '{6'h28, 6'h00, 5'h00, 15'b0101_0000_00_00_001};
    dec[10] = '{6'h35, 6'h00, 5'h00, 15'b0000_1101_01_01_001};
    dec[11] = '{6'h3d, 6'h00, 5'h00, 15'b0001_0101_00_00_001};
    dec[12] = '{6'h11, 6'h00, 5'h11, 15'b0000_1101_10_00_111};
    dec[13] = '{6'h11, 6'h32, 5'h10, 15'b0000_0100_00_00_111};
    dec[14] = '{6'h11, 6'h00, 5'h08, 15'b0000_0100_00_00_111};
    dec[15] = '{6'h3f, 6'h00, 5'h00, 15'b0000_0000_00_00_000};
    dec[16] = '{6'h00, 6'h18, 5'h00, 15'b0000_0000_00_00_000};
`ifdef ALU_MULT_EN
    dec[17] = '{6'h00, 6'h10, 5'h00, 15'b0000_1000_00_00_000};
`else
    dec[17] = '{6'h00, 6'h10, 5'h00, 15'b0000_0000_00_00_000};
`endif
    alu[0]  = '{3'b000, 6'h20, 32'h7fffffff, 32'h00000001, 16'h0, 32'h80000000, 1'b1, 1'b0, 1'b0};
    alu[1]  = '{3'b000, 6'h21, 32'h00000001, 32'h00000002, 16'h0, 32'h00000003, 1'b0, 1'b0, 1'b0};
    alu[2]  = '{3'b000, 6'h22, 32'h00000005, 32'h00000005, 16'h0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    alu[3]  = '{3'b000, 6'h22, 32'h80000000, 32'h00000001, 16'h0, 32'h7fffffff, 1'b1, 1'b0, 1'b0};
    alu[4]  = '{3'b000, 6'h24, 32'h0f0f0f0f, 32'h00ff00ff, 16'h0, 32'h000f000f, 1'b0, 1'b0, 1'b0};
    alu[5]  = '{3'b000, 6'h27, 32'h0f0f0f0f, 32'h00ff00ff, 16'h0, 32'hf000f000, 1'b0, 1'b0, 1'b0};
    alu[6]  = '{3'b000, 6'h26, 32'h000000ff, 32'h0000000f, 16'h0, 32'h000000f0, 1'b0, 1'b0, 1'b0};
    alu[7]  = '{3'b000, 6'h2a, 32'hffffffff, 32'h00000001, 16'h0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    alu[8]  = '{3'b000, 6'h2b, 32'hffffffff, 32'h00000001, 16'h0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    alu[9]  = '{3'b000, 6'h00, 32'h00000004, 32'h00000001, 16'h0, 32'h00000010, 1'b0, 1'b0, 1'b0};
    alu[10] = '{3'b000, 6'h02, 32'h00000004, 32'h80000000, 16'h0, 32'h08000000, 1'b0, 1'b0, 1'b0};
    alu[11] = '{3'b000, 6'h03, 32'h00000004, 32'h80000000, 16'h0, 32'hf8000000, 1'b0, 1'b0, 1'b0};
    alu[12] = '{3'b001, 6'h00, 32'h00000010, 32'h0, 16'hffff, 32'h0000000f, 1'b0, 1'b0, 1'b0};
    alu[13] = '{3'b100, 6'h00, 32'hfffffffe, 32'h0, 16'hffff, 32'h00000001, 1'b0, 1'b0, 1'b0};
    alu[14] = '{3'b101, 6'h00, 32'hffffffff, 32'h0, 16'h8000, 32'h00008000, 1'b0, 1'b0, 1'b0};
    alu[15] = '{3'b110, 6'h00, 32'h12340000, 32'h0, 16'h8000, 32'h12348000, 1'b0, 1'b0, 1'b0};
    alu[16] = '{3'b010, 6'h00, 32'h00000005, 32'h00000005, 16'h0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    alu[17] = '{3'b011, 6'h00, 32'h00000005, 32'h00000005, 16'h0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    alu[18] = '{3'b011, 6'h00, 32'h00000005, 32'h00000006, 16'h0, 32'hffffffff, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; id_op = '0; id_fun = '0; id_fmt = '0; ex_imm = '0; ex_kill = 1'b0; fp_cond = 1'b0;
    set_ex(3'b000, 6'h20, 5'h0, 1'b0, 32'h0, 32'h0);
    repeat (2) step();
    chk("reset_fpc", {31'h0, fpc}, 32'h0);
    rst_n = 1'b1;
    ex_kill = 1'b1;
    for (int i = 0; i < ND; i++) begin
      id_op = dec[i].op; id_fun = dec[i].fun; id_fmt = dec[i].fmt;
      #1;
      chk($sformatf("dec%0d_op%h_fun%h", i, dec[i].op, dec[i].fun), {17'h0, ctrl}, {17'h0, dec[i].exp});
    end
    for (int i = 0; i < NA; i++) begin
      set_ex(alu[i].op, alu[i].fun, 5'h0, 1'b0, alu[i].a, alu[i].rt);
      ex_imm = alu[i].imm;
      #1;
      chk($sformatf("alu%0d_result", i), ex_result, alu[i].res);
      chk($sformatf("alu%0d_ovf", i), {31'h0, ex_overflow}, {31'h0, alu[i].ovf});
      chk($sformatf("alu%0d_zero", i), {31'h0, ex_zero}, {31'h0, alu[i].zero});
      chk($sformatf("alu%0d_br", i), {31'h0, br_taken}, {31'h0, alu[i].br});
      chk($sformatf("alu%0d_out2", i), ex_out2, 32'h0);
    end

    ex_kill = 1'b0;
    set_ex(3'b111, 6'h32, 5'h10, 1'b0, 32'h0, 32'h0);
    fp_cond = 1'b1;
    #1;
    chk("fpc_before_write", {31'h0, fpc}, 32'h0);
    step();
    chk("fpc_after_cmp", {31'h0, fpc}, 32'h1);
    set_ex(3'b111, 6'h00, 5'h08, 1'b1, 32'h0, 32'h0);
    #1;
    chk("bc1t_taken", {31'h0, br_taken}, 32'h1);
    ex_ft0 = 1'b0;
    #1;
    chk("bc1f_not_taken", {31'h0, br_taken}, 32'h0);
    set_ex(3'b111, 6'h3c, 5'h10, 1'b0, 32'h0, 32'h0);
    fp_cond = 1'b0; ex_kill = 1'b1;
    step();
    chk("fpc_kill_hold", {31'h0, fpc}, 32'h1);
    ex_kill = 1'b0; fp_cond = 1'b1; rst_n = 1'b0;
    step();
    chk("fpc_reset_priority", {31'h0, fpc}, 32'h0);
    rst_n = 1'b1;
    set_ex(3'b111, 6'h00, 5'h08, 1'b1, 32'h0, 32'h0);
    #1;
    chk("bc1t_after_reset", {31'h0, br_taken}, 32'h0);
    ex_ft0 = 1'b0;
    #1;
    chk("bc1f_after_reset", {31'h0, br_taken}, 32'h1);

`ifdef ALU_MULT_EN
    set_ex(3'b000, 6'h10, 5'h0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("hi_reset", ex_result, 32'h0);
    set_ex(3'b000, 6'h18, 5'h0, 1'b0, 32'hffffffff, 32'h00000002);
    #1;
    chk("mult_lo_out", ex_result, 32'hfffffffe);
    chk("mult_hi_out2", ex_out2, 32'hffffffff);
    step();
    ex_fun = 6'h10;
    #1;
    chk("mfhi_after_mult", ex_result, 32'hffffffff);
    ex_fun = 6'h12;
    #1;
    chk("mflo_after_mult", ex_result, 32'hfffffffe);
    set_ex(3'b000, 6'h19, 5'h0, 1'b0, 32'h3, 32'h3);
    ex_kill = 1'b1;
    step();
    ex_kill = 1'b0;
    ex_fun = 6'h10;
    #1;
    chk("mfhi_kill_hold", ex_result, 32'hffffffff);
    set_ex(3'b000, 6'h19, 5'h0, 1'b0, 32'hffffffff, 32'hffffffff);
    #1;
    chk("multu_out2", ex_out2, 32'hfffffffe);
    step();
    ex_fun = 6'h10;
    #1;
    chk("mfhi_multu", ex_result, 32'hfffffffe);
    ex_fun = 6'h12;
    #1;
    chk("mflo_multu", ex_result, 32'h00000001);
`else
    set_ex(3'b000, 6'h18, 5'h0, 1'b0, 32'hffffffff, 32'h00000002);
    #1;
    chk("mult_disabled_out2", ex_out2, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
